ahbl_arbiter_2m: RTL and testbench

Two-master AHB-Lite arbiter. The CPU (M0) and the accelerator/DMA master (M1) share one AHB-Lite slave port, e.g. the register slave whose registers are selected by HADDR[27:24].
- Arbitrates address phases and stalls the losing master with HREADY low.
- Tracks the data-phase owner so HWDATA and HRDATA are steered to the right master.
- Holds read data for a master whose data phase completed while it was stalled.

---
 rtl/ahbl_pkg.sv | 27 ++
 rtl/ahbl_arbiter_2m_if.sv | 50 +++++
 rtl/ahbl_arb_rr2.sv | 61 ++++++
 rtl/ahbl_arbiter_2m.sv | 101 ++++++++++
 tb/tb_ahbl_arbiter_2m.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and payload types for the two-master arbiter.
package ahbl_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TRANS_W = 2;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned MIDX_W  = 1;

    localparam logic [TRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [TRANS_W-1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [SIZE_W-1:0] HSIZE_BYTE = 3'b000;
    localparam logic [SIZE_W-1:0] HSIZE_HALF = 3'b001;
    localparam logic [SIZE_W-1:0] HSIZE_WORD = 3'b010;

    typedef logic [MIDX_W-1:0] midx_t;

    // Address-phase control bundle of one master
    typedef struct packed {
        logic [ADDR_W-1:0]  haddr;
        logic [TRANS_W-1:0] htrans;
        logic [SIZE_W-1:0]  hsize;
        logic               hwrite;
    } ahb_ap_t;

endpackage

// File: rtl/ahbl_arbiter_2m_if.sv
// Bus bundle around ahbl_arbiter_2m: two master ports and one shared slave port.
interface ahbl_arbiter_2m_if;
    import ahbl_pkg::*;

    logic [ADDR_W-1:0]  M0_HADDR;
    logic [TRANS_W-1:0] M0_HTRANS;
    logic [SIZE_W-1:0]  M0_HSIZE;
    logic               M0_HWRITE;
    logic [DATA_W-1:0]  M0_HWDATA;
    logic               M0_HREADY;
    logic [DATA_W-1:0]  M0_HRDATA;

    logic [ADDR_W-1:0]  M1_HADDR;
    logic [TRANS_W-1:0] M1_HTRANS;
    logic [SIZE_W-1:0]  M1_HSIZE;
    logic               M1_HWRITE;
    logic [DATA_W-1:0]  M1_HWDATA;
    logic               M1_HREADY;
    logic [DATA_W-1:0]  M1_HRDATA;

    logic [ADDR_W-1:0]  S_HADDR;
    logic [TRANS_W-1:0] S_HTRANS;
    logic [SIZE_W-1:0]  S_HSIZE;
    logic               S_HWRITE;
    logic [DATA_W-1:0]  S_HWDATA;
    logic               S_HREADY;
    logic               S_HREADYOUT;
    logic [DATA_W-1:0]  S_HRDATA;

    // Arbiter side: slave to both masters, drives the shared slave port
    modport slave (
        input  M0_HADDR, M0_HTRANS, M0_HSIZE, M0_HWRITE, M0_HWDATA,
        output M0_HREADY, M0_HRDATA,
        input  M1_HADDR, M1_HTRANS, M1_HSIZE, M1_HWRITE, M1_HWDATA,
        output M1_HREADY, M1_HRDATA,
        output S_HADDR, S_HTRANS, S_HSIZE, S_HWRITE, S_HWDATA, S_HREADY,
        input  S_HREADYOUT, S_HRDATA
    );

    // Environment side: the two masters plus the slave
    modport master (
        output M0_HADDR, M0_HTRANS, M0_HSIZE, M0_HWRITE, M0_HWDATA,
        input  M0_HREADY, M0_HRDATA,
        output M1_HADDR, M1_HTRANS, M1_HSIZE, M1_HWRITE, M1_HWDATA,
        input  M1_HREADY, M1_HRDATA,
        input  S_HADDR, S_HTRANS, S_HSIZE, S_HWRITE, S_HWDATA, S_HREADY,
        output S_HREADYOUT, S_HRDATA
    );

endinterface

// File: rtl/ahbl_arb_rr2.sv
// Two-way address-phase grant (round-robin or fixed M0 priority) with a lock
// that freezes the grant while the slave stalls a presented address phase.
module ahbl_arb_rr2
    import ahbl_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [1:0] req_i,
    input  logic       hready_i,
    output midx_t      gnt_c,
    output logic       gnt_req_c
);

    midx_t last_gnt_q, last_gnt_d;
    logic  ap_lock_q,  ap_lock_d;
    midx_t ap_owner_q, ap_owner_d;

    always_comb begin
        gnt_c = last_gnt_q;
        if (ap_lock_q) begin
            gnt_c = ap_owner_q;
        end else begin
            case (req_i)
                2'b01:   gnt_c = 1'b0;
                2'b10:   gnt_c = 1'b1;
                2'b11:   gnt_c = FIXED_PRIO ? 1'b0 : ~last_gnt_q;
                default: gnt_c = last_gnt_q;
            endcase
        end
        gnt_req_c = req_i[gnt_c];
    end

    // Lock is taken on a stalled granted request and dropped on any ready cycle
    always_comb begin
        last_gnt_d = last_gnt_q;
        ap_lock_d  = ap_lock_q;
        ap_owner_d = ap_owner_q;
        if (hready_i) begin
            ap_lock_d = 1'b0;
            if (gnt_req_c) last_gnt_d = gnt_c;
        end else if (gnt_req_c) begin
            ap_lock_d  = 1'b1;
            ap_owner_d = gnt_c;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_gnt_q <= 1'b1;
            ap_lock_q  <= 1'b0;
            ap_owner_q <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            ap_lock_q  <= ap_lock_d;
            ap_owner_q <= ap_owner_d;
        end
    end

endmodule

// File: rtl/ahbl_arbiter_2m.sv
// Two-master AHB-Lite arbiter: shares one slave port between M0 and M1,
// steering write/read data by data-phase owner and holding stalled read data.
module ahbl_arbiter_2m
    import ahbl_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahbl_arbiter_2m_if.slave bus
);

    logic [1:0]             req;
    midx_t                  gnt_c;
    logic                   gnt_req_c;
    ahb_ap_t                ap_m0, ap_m1, ap_c;
    logic                   dp_active_q, dp_active_d;
    midx_t                  dp_owner_q,  dp_owner_d;
    logic [1:0]             done_q, done_d;
    logic [1:0]             hready_c;
    logic [1:0][DATA_W-1:0] rdata_hold_q, rdata_hold_d;

    assign req   = {bus.M1_HTRANS[1], bus.M0_HTRANS[1]};
    assign ap_m0 = '{haddr: bus.M0_HADDR, htrans: bus.M0_HTRANS,
                     hsize: bus.M0_HSIZE, hwrite: bus.M0_HWRITE};
    assign ap_m1 = '{haddr: bus.M1_HADDR, htrans: bus.M1_HTRANS,
                     hsize: bus.M1_HSIZE, hwrite: bus.M1_HWRITE};

    ahbl_arb_rr2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req_i     (req),
        .hready_i  (bus.S_HREADYOUT),
        .gnt_c     (gnt_c),
        .gnt_req_c (gnt_req_c)
    );

    // SEQ is forwarded as NONSEQ since consecutive beats may be interleaved
    always_comb begin
        ap_c        = gnt_c ? ap_m1 : ap_m0;
        ap_c.htrans = gnt_req_c ? HTRANS_NONSEQ : HTRANS_IDLE;
    end

    always_comb begin
        hready_c = 2'b11;
        for (int i = 0; i < 2; i++) begin
            if (req[i] && (gnt_c != MIDX_W'(i)))
                hready_c[i] = 1'b0;
            else if (dp_active_q && (dp_owner_q == MIDX_W'(i)) && !done_q[i])
                hready_c[i] = bus.S_HREADYOUT;
            else if (req[i])
                hready_c[i] = bus.S_HREADYOUT;
        end
    end

    // A finished data phase whose master is still stalled parks its read data
    always_comb begin
        dp_active_d  = dp_active_q;
        dp_owner_d   = dp_owner_q;
        done_d       = done_q;
        rdata_hold_d = rdata_hold_q;
        if (bus.S_HREADYOUT) begin
            dp_active_d = gnt_req_c;
            if (gnt_req_c) dp_owner_d = gnt_c;
        end
        for (int i = 0; i < 2; i++) begin
            if (dp_active_q && (dp_owner_q == MIDX_W'(i)) && bus.S_HREADYOUT && !hready_c[i]) begin
                done_d[i]       = 1'b1;
                rdata_hold_d[i] = bus.S_HRDATA;
            end else if (hready_c[i]) begin
                done_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_active_q  <= 1'b0;
            dp_owner_q   <= 1'b0;
            done_q       <= 2'b00;
            rdata_hold_q <= '0;
        end else begin
            dp_active_q  <= dp_active_d;
            dp_owner_q   <= dp_owner_d;
            done_q       <= done_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign bus.S_HADDR   = ap_c.haddr;
    assign bus.S_HTRANS  = ap_c.htrans;
    assign bus.S_HSIZE   = ap_c.hsize;
    assign bus.S_HWRITE  = ap_c.hwrite;
    assign bus.S_HWDATA  = (dp_active_q && (dp_owner_q == 1'b1)) ? bus.M1_HWDATA : bus.M0_HWDATA;
    assign bus.S_HREADY  = bus.S_HREADYOUT;
    assign bus.M0_HREADY = hready_c[0];
    assign bus.M1_HREADY = hready_c[1];
    assign bus.M0_HRDATA = done_q[0] ? rdata_hold_q[0] : bus.S_HRDATA;
    assign bus.M1_HRDATA = done_q[1] ? rdata_hold_q[1] : bus.S_HRDATA;

endmodule

// File: tb/tb_ahbl_arbiter_2m.sv
// Bench for ahbl_arbiter_2m: round-robin and fixed-priority instances share
// stimulus and are compared each cycle against a rule-level reference model.
module tb_ahbl_arbiter_2m;
    import ahbl_pkg::*;

    localparam int unsigned HALF   = 10;
    localparam int unsigned N_RAND = 3000;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #(HALF) HCLK = ~HCLK;

    logic [1:0][31:0] m_haddr, m_hwdata;
    logic [1:0][1:0]  m_htrans;
    logic [1:0][2:0]  m_hsize;
    logic [1:0]       m_hwrite;
    logic             s_hreadyout;
    logic [31:0]      s_hrdata;

    logic [1:0][31:0]       o_haddr, o_hwdata;
    logic [1:0][1:0]        o_htrans;
    logic [1:0][2:0]        o_hsize;
    logic [1:0]             o_hwrite, o_s_hready;
    logic [1:0][1:0]        o_hready;
    logic [1:0][1:0][31:0]  o_hrdata;

    // Instance 0: round-robin, instance 1: fixed priority
    for (genvar k = 0; k < 2; k++) begin : g_dut
        ahbl_arbiter_2m_if bus ();
        assign bus.M0_HADDR    = m_haddr[0];
        assign bus.M0_HTRANS   = m_htrans[0];
        assign bus.M0_HSIZE    = m_hsize[0];
        assign bus.M0_HWRITE   = m_hwrite[0];
        assign bus.M0_HWDATA   = m_hwdata[0];
        assign bus.M1_HADDR    = m_haddr[1];
        assign bus.M1_HTRANS   = m_htrans[1];
        assign bus.M1_HSIZE    = m_hsize[1];
        assign bus.M1_HWRITE   = m_hwrite[1];
        assign bus.M1_HWDATA   = m_hwdata[1];
        assign bus.S_HREADYOUT = s_hreadyout;
        assign bus.S_HRDATA    = s_hrdata;

        ahbl_arbiter_2m #(.FIXED_PRIO(k == 1)) u_dut (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .bus     (bus)
        );

        assign o_haddr[k]     = bus.S_HADDR;
        assign o_htrans[k]    = bus.S_HTRANS;
        assign o_hsize[k]     = bus.S_HSIZE;
        assign o_hwrite[k]    = bus.S_HWRITE;
        assign o_hwdata[k]    = bus.S_HWDATA;
        assign o_s_hready[k]  = bus.S_HREADY;
        assign o_hready[k]    = {bus.M1_HREADY, bus.M0_HREADY};
        assign o_hrdata[k][0] = bus.M0_HRDATA;
        assign o_hrdata[k][1] = bus.M1_HRDATA;
    end

    // Reference model state, per instance
    int          lastg [2], lock [2], aown [2], dpa [2], dpo [2];
    int          done  [2][2];
    logic [31:0] hold  [2][2];
    int          n_lastg [2], n_lock [2], n_aown [2], n_dpa [2], n_dpo [2];
    int          n_done  [2][2];
    logic [31:0] n_hold  [2][2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            lastg[k] = 1; lock[k] = 0; aown[k] = 0; dpa[k] = 0; dpo[k] = 0;
            n_lastg[k] = 1; n_lock[k] = 0; n_aown[k] = 0; n_dpa[k] = 0; n_dpo[k] = 0;
            for (int i = 0; i < 2; i++) begin
                done[k][i] = 0; hold[k][i] = '0; n_done[k][i] = 0; n_hold[k][i] = '0;
            end
        end
    endtask

    // Predict this cycle's outputs, compare, and work out the post-edge state
    task automatic model_check(input int k);
        int r [2];
        int rdy [2];
        int g, greq, nreq;
        logic [31:0] exp_rd;
        r[0] = int'(m_htrans[0][1]);
        r[1] = int'(m_htrans[1][1]);
        nreq = r[0] + r[1];
        if (lock[k] != 0)  g = aown[k];
        else if (nreq == 1) g = r[1];
        else if (nreq == 2) g = (k == 1) ? 0 : 1 - lastg[k];
        else                g = lastg[k];
        greq = r[g];

        check_eq($sformatf("k%0d s_haddr", k),  o_haddr[k], m_haddr[g]);
        check_eq($sformatf("k%0d s_htrans", k), 32'(o_htrans[k]), (greq != 0) ? 32'h2 : 32'h0);
        check_eq($sformatf("k%0d s_hsize", k),  32'(o_hsize[k]), 32'(m_hsize[g]));
        check_eq($sformatf("k%0d s_hwrite", k), 32'(o_hwrite[k]), 32'(m_hwrite[g]));
        check_eq($sformatf("k%0d s_hwdata", k), o_hwdata[k],
                 m_hwdata[(dpa[k] != 0 && dpo[k] == 1) ? 1 : 0]);
        check_eq($sformatf("k%0d s_hready", k), 32'(o_s_hready[k]), 32'(s_hreadyout));

        for (int i = 0; i < 2; i++) begin
            if (r[i] != 0 && g != i)                           rdy[i] = 0;
            else if (dpa[k] != 0 && dpo[k] == i && done[k][i] == 0) rdy[i] = int'(s_hreadyout);
            else if (r[i] != 0)                                rdy[i] = int'(s_hreadyout);
            else                                               rdy[i] = 1;
            exp_rd = (done[k][i] != 0) ? hold[k][i] : s_hrdata;
            check_eq($sformatf("k%0d m%0d_hready", k, i), 32'(o_hready[k][i]), 32'(rdy[i]));
            check_eq($sformatf("k%0d m%0d_hrdata", k, i), o_hrdata[k][i], exp_rd);
        end

        n_lastg[k] = lastg[k]; n_lock[k] = lock[k]; n_aown[k] = aown[k];
        n_dpa[k] = dpa[k]; n_dpo[k] = dpo[k];
        if (s_hreadyout) begin
            n_lock[k] = 0;
            if (greq != 0) begin
                n_lastg[k] = g; n_dpo[k] = g; n_dpa[k] = 1;
            end else begin
                n_dpa[k] = 0;
            end
        end else if (greq != 0) begin
            n_lock[k] = 1; n_aown[k] = g;
        end
        for (int i = 0; i < 2; i++) begin
            n_done[k][i] = done[k][i];
            n_hold[k][i] = hold[k][i];
            if (dpa[k] != 0 && dpo[k] == i && s_hreadyout && rdy[i] == 0) begin
                n_done[k][i] = 1; n_hold[k][i] = s_hrdata;
            end else if (rdy[i] != 0) begin
                n_done[k][i] = 0;
            end
        end
    endtask

    task automatic eval_cycle();
        #2;
        for (int k = 0; k < 2; k++) model_check(k);
    endtask

    task automatic tick();
        @(posedge HCLK);
        lastg = n_lastg; lock = n_lock; aown = n_aown; dpa = n_dpa; dpo = n_dpo;
        done = n_done; hold = n_hold;
        @(negedge HCLK);
    endtask

    task automatic set_m(input int i, input logic [1:0] tr, input logic [31:0] addr,
                         input logic wr, input logic [31:0] wdata);
        m_htrans[i] = tr; m_haddr[i] = addr; m_hwrite[i] = wr;
        m_hwdata[i] = wdata; m_hsize[i] = HSIZE_WORD;
    endtask

    task automatic idle_all();
        set_m(0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
        set_m(1, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
        s_hrdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        idle_all();
        s_hreadyout = 1'b1;
        model_reset();
        eval_cycle();
        check_eq("rst m0_hready", 32'(o_hready[0][0]), 32'h1);
        check_eq("rst m1_hready", 32'(o_hready[0][1]), 32'h1);
        check_eq("rst s_htrans",  32'(o_htrans[0]),    32'h0);
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        idle_all();
        s_hreadyout = 1'b1;
        model_reset();
        do_reset();

        // M0-only write, zero added latency
        set_m(0, HTRANS_NONSEQ, 32'h0100_0000, 1'b1, 32'h0);
        eval_cycle();
        check_eq("wr s_htrans", 32'(o_htrans[0]), 32'h2);
        check_eq("wr m1_hready ap", 32'(o_hready[0][1]), 32'h1);
        tick();
        set_m(0, HTRANS_IDLE, 32'h0, 1'b0, 32'h1234_5678);
        eval_cycle();
        check_eq("wr s_hwdata", o_hwdata[0], 32'h1234_5678);
        check_eq("wr m1_hready dp", 32'(o_hready[0][1]), 32'h1);
        tick();

        // Ties: round-robin alternates, fixed priority keeps M0
        do_reset();
        set_m(0, HTRANS_NONSEQ, 32'h0100_0010, 1'b1, 32'h0);
        set_m(1, HTRANS_NONSEQ, 32'h0200_0020, 1'b1, 32'h0);
        eval_cycle();
        check_eq("tie1 rr haddr", o_haddr[0], 32'h0100_0010);
        check_eq("tie1 rr m1_hready", 32'(o_hready[0][1]), 32'h0);
        check_eq("tie1 fp haddr", o_haddr[1], 32'h0100_0010);
        tick();
        set_m(0, HTRANS_NONSEQ, 32'h0100_0014, 1'b1, 32'h0);
        eval_cycle();
        check_eq("tie2 rr haddr", o_haddr[0], 32'h0200_0020);
        check_eq("tie2 rr m0_hready", 32'(o_hready[0][0]), 32'h0);
        check_eq("tie2 fp haddr", o_haddr[1], 32'h0100_0014);
        check_eq("tie2 fp m1_hready", 32'(o_hready[1][1]), 32'h0);
        tick();
        set_m(0, HTRANS_NONSEQ, 32'h0100_0018, 1'b1, 32'h0);
        eval_cycle();
        check_eq("tie3 fp haddr", o_haddr[1], 32'h0100_0018);
        tick();
        set_m(0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
        eval_cycle();
        check_eq("m0idle fp haddr", o_haddr[1], 32'h0200_0020);
        check_eq("m0idle fp m1_hready", 32'(o_hready[1][1]), 32'h1);
        tick();

        // M1 read completes while M1 loses the next arbitration
        do_reset();
        set_m(1, HTRANS_NONSEQ, 32'h0200_0000, 1'b0, 32'h0);
        eval_cycle();
        tick();
        set_m(0, HTRANS_NONSEQ, 32'h0100_0000, 1'b0, 32'h0);
        set_m(1, HTRANS_NONSEQ, 32'h0200_0004, 1'b0, 32'h0);
        s_hrdata = 32'hCAFE_F00D;
        eval_cycle();
        check_eq("hold m1_hready lose", 32'(o_hready[0][1]), 32'h0);
        tick();
        set_m(0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
        s_hrdata = 32'hDEAD_BEEF;
        s_hreadyout = 1'b0;
        eval_cycle();
        check_eq("hold m1_hrdata stall", o_hrdata[0][1], 32'hCAFE_F00D);
        tick();
        s_hreadyout = 1'b1;
        eval_cycle();
        check_eq("hold m1_hready go", 32'(o_hready[0][1]), 32'h1);
        check_eq("hold m1_hrdata go", o_hrdata[0][1], 32'hCAFE_F00D);
        tick();
        set_m(1, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
        s_hrdata = 32'h1111_2222;
        eval_cycle();
        check_eq("hold m1_hrdata freed", o_hrdata[0][1], 32'h1111_2222);
        tick();

        // Slave wait states lock the grant on M0 although round-robin favours M1
        do_reset();
        set_m(0, HTRANS_NONSEQ, 32'h0100_0030, 1'b1, 32'h0);
        eval_cycle();
        tick();
        set_m(0, HTRANS_NONSEQ, 32'h0100_0040, 1'b1, 32'h0);
        s_hreadyout = 1'b0;
        eval_cycle();
        tick();
        set_m(1, HTRANS_NONSEQ, 32'h0200_0040, 1'b0, 32'h0);
        eval_cycle();
        check_eq("lock haddr ws", o_haddr[0], 32'h0100_0040);
        check_eq("lock m1_hready ws", 32'(o_hready[0][1]), 32'h0);
        tick();
        s_hreadyout = 1'b1;
        eval_cycle();
        check_eq("lock haddr rel", o_haddr[0], 32'h0100_0040);
        tick();
        set_m(0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
        eval_cycle();
        check_eq("lock m1 granted", o_haddr[0], 32'h0200_0040);
        check_eq("lock m1_hready", 32'(o_hready[0][1]), 32'h1);
        tick();

        // Asynchronous reset during an M1 data phase
        do_reset();
        set_m(1, HTRANS_NONSEQ, 32'h0200_0050, 1'b1, 32'h0);
        eval_cycle();
        tick();
        set_m(1, HTRANS_IDLE, 32'h0, 1'b0, 32'hA5A5_0001);
        m_hwdata[0] = 32'h5A5A_0002;
        s_hreadyout = 1'b0;
        eval_cycle();
        check_eq("rstmid hwdata pre", o_hwdata[0], 32'hA5A5_0001);
        HRESETn = 1'b0;
        model_reset();
        #1;
        eval_cycle();
        check_eq("rstmid m0_hready", 32'(o_hready[0][0]), 32'h1);
        check_eq("rstmid m1_hready", 32'(o_hready[0][1]), 32'h1);
        check_eq("rstmid s_htrans", 32'(o_htrans[0]), 32'h0);
        check_eq("rstmid hwdata", o_hwdata[0], 32'h5A5A_0002);
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < int'(N_RAND); n++) begin
            for (int i = 0; i < 2; i++) begin
                m_htrans[i] = 2'($urandom_range(0, 3));
                m_haddr[i]  = $urandom;
                m_hsize[i]  = 3'($urandom_range(0, 2));
                m_hwrite[i] = 1'($urandom_range(0, 1));
                m_hwdata[i] = $urandom;
            end
            s_hreadyout = ($urandom_range(0, 3) != 0);
            s_hrdata    = $urandom;
            eval_cycle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
